// File: rtl/slot_allocator.sv
// Slot allocator: lowest-free-index grant with registered occupancy bitmap and count.
// Optional illegal-free sticky flag enabled by defining SLOT_ALLOC_FREE_CHECK_EN.
module slot_allocator #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_req,
  output logic                       alloc_gnt,
  output logic [$clog2(WIDTH)-1:0]   alloc_idx,
  input  logic                       free_valid,
  input  logic [$clog2(WIDTH)-1:0]   free_idx,
  input  logic                       flush,
  output logic [WIDTH-1:0]           busy_mask,
  output logic [$clog2(WIDTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       free_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] busy_mask_q, busy_mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             free_hit;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    alloc_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!busy_mask_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign full      = (count_q == CNT_W'(WIDTH));
  assign empty     = (count_q == '0);
  assign alloc_gnt = alloc_req && !full && !flush;
  assign free_hit  = free_valid && busy_mask_q[free_idx];

  always_comb begin
    busy_mask_d = busy_mask_q;
    count_d     = count_q;
    if (flush) begin
      busy_mask_d = '0;
      count_d     = '0;
    end else begin
      if (free_hit) busy_mask_d[free_idx] = 1'b0;
      if (alloc_gnt) busy_mask_d[alloc_idx] = 1'b1;
      count_d = count_q + CNT_W'(alloc_gnt) - CNT_W'(free_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask_q <= '0;
      count_q     <= '0;
    end else begin
      busy_mask_q <= busy_mask_d;
      count_q     <= count_d;
    end
  end

  assign busy_mask = busy_mask_q;
  assign count     = count_q;

`ifdef SLOT_ALLOC_FREE_CHECK_EN
  logic free_err_q, free_err_d;

  always_comb begin
    free_err_d = free_err_q | (free_valid && !flush && !busy_mask_q[free_idx]);
  end

  always_ff @(posedge clk) begin
    if (reset) free_err_q <= 1'b0;
    else       free_err_q <= free_err_d;
  end

  assign free_err = free_err_q;
`else
  assign free_err = 1'b0;
`endif

endmodule
